// File: rtl/bus_alu_datapath.sv
// Shared-bus datapath slice: R0-R7, add/sub pipeline (A, G) and OR pipeline (B, H)
// around a 13-source priority bus multiplexer. All sequencing lives in the external controller.
module bus_alu_datapath #(
   parameter int W = 16
) (
   input  logic         Clock,
   input  logic         Resetn,
   input  logic [W-1:0] DIN,
   input  logic [W-1:0] Iext,
   input  logic [W-1:0] Jext,
   input  logic [12:0]  Control,
   input  logic [7:0]   Rin,
   input  logic         Ain,
   input  logic         Bin,
   input  logic         Gin,
   input  logic         Hin,
   input  logic         AddSubControl,
   output logic [W-1:0] BusWires,
   output logic [W-1:0] G,
   output logic [W-1:0] H
);

   logic [W-1:0] r [8];
   logic [W-1:0] a_reg;
   logic [W-1:0] b_reg;
   logic [W-1:0] addsub_result;
   logic [W-1:0] or_result;

   // Later assignments override earlier ones, so the highest-index set bit wins.
   always_comb begin
      BusWires = '0;
      for (int i = 0; i < 8; i++) begin
         if (Control[i]) BusWires = r[i];
      end
      if (Control[8])  BusWires = G;
      if (Control[9])  BusWires = H;
      if (Control[10]) BusWires = Iext;
      if (Control[11]) BusWires = Jext;
      if (Control[12]) BusWires = DIN;
   end

   always_comb begin
      addsub_result = AddSubControl ? (a_reg - BusWires) : (a_reg + BusWires);
      or_result     = b_reg | BusWires;
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         for (int i = 0; i < 8; i++) r[i] <= '0;
         a_reg <= '0;
         b_reg <= '0;
         G     <= '0;
         H     <= '0;
      end else begin
         for (int i = 0; i < 8; i++) begin
            if (Rin[i]) r[i] <= BusWires;
         end
         if (Ain) a_reg <= BusWires;
         if (Bin) b_reg <= BusWires;
         if (Gin) G     <= addsub_result;
         if (Hin) H     <= or_result;
      end
   end

endmodule

// File: tb/tb_bus_alu_datapath.sv
// Bench for bus_alu_datapath: directed vector table, randomized traffic against a
// register-file model, and an asynchronous reset sequence.
module tb_bus_alu_datapath;

   localparam int W = 16;

   logic         Clock;
   logic         Resetn;
   logic [W-1:0] DIN, Iext, Jext;
   logic [12:0]  Control;
   logic [7:0]   Rin;
   logic         Ain, Bin, Gin, Hin, AddSubControl;
   logic [W-1:0] BusWires, G, H;

   bus_alu_datapath #(.W(W)) dut (
      .Clock(Clock), .Resetn(Resetn), .DIN(DIN), .Iext(Iext), .Jext(Jext),
      .Control(Control), .Rin(Rin), .Ain(Ain), .Bin(Bin), .Gin(Gin), .Hin(Hin),
      .AddSubControl(AddSubControl), .BusWires(BusWires), .G(G), .H(H)
   );

   // clock / reset
   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int checks = 0;
   int errors = 0;
   logic [W-1:0] exp_q[$];

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
      end
   endtask

   // behavioural model: architectural registers as plain values
   logic [W-1:0] mr [8];
   logic [W-1:0] ma, mb, mg, mh;

   task automatic model_reset();
      for (int i = 0; i < 8; i++) mr[i] = '0;
      ma = '0; mb = '0; mg = '0; mh = '0;
   endtask

   function automatic logic [W-1:0] model_bus(input logic [12:0] ctrl);
      logic [W-1:0] src [13];
      for (int i = 0; i < 8; i++) src[i] = mr[i];
      src[8] = mg; src[9] = mh; src[10] = Iext; src[11] = Jext; src[12] = DIN;
      for (int i = 12; i >= 0; i--) begin
         if (ctrl[i]) return src[i];
      end
      return '0;
   endfunction

   // driver: called just after a falling edge; runs one full clock step
   task automatic drive(input logic [12:0] ctrl, input logic [W-1:0] din,
                        input logic [7:0] rin, input logic ain, input logic bin,
                        input logic gin, input logic hin, input logic sub,
                        input logic use_table, input logic [W-1:0] eb,
                        input logic [W-1:0] eg, input logic [W-1:0] eh,
                        input string tag);
      logic [W-1:0] bus_v, old_a;
      Control = ctrl; DIN = din; Rin = rin; Ain = ain; Bin = bin;
      Gin = gin; Hin = hin; AddSubControl = sub;
      #1;
      bus_v = model_bus(ctrl);
      exp_q.push_back(use_table ? eb : bus_v);
      check({tag, "_bus"}, BusWires, exp_q.pop_front());
      @(posedge Clock);
      old_a = ma;
      for (int i = 0; i < 8; i++) if (rin[i]) mr[i] = bus_v;
      if (ain) ma = bus_v;
      if (bin) mb = mb | 16'h0 ? mb : mb;
      if (bin) mb = bus_v;
      if (gin) mg = sub ? old_a - bus_v : old_a + bus_v;
      if (hin) mh = mh_or(bus_v);
      exp_q.push_back(use_table ? eg : mg);
      exp_q.push_back(use_table ? eh : mh);
      #1;
      check({tag, "_G"}, G, exp_q.pop_front());
      check({tag, "_H"}, H, exp_q.pop_front());
      @(negedge Clock);
   endtask

   // OR result uses B as it stood before the edge
   logic [W-1:0] mb_pre;
   function automatic logic [W-1:0] mh_or(input logic [W-1:0] bus_v);
      return mb_pre | bus_v;
   endfunction

   task automatic step(input logic [12:0] ctrl, input logic [W-1:0] din,
                       input logic [7:0] rin, input logic ain, input logic bin,
                       input logic gin, input logic hin, input logic sub,
                       input logic use_table, input logic [W-1:0] eb,
                       input logic [W-1:0] eg, input logic [W-1:0] eh, input string tag);
      mb_pre = mb;
      drive(ctrl, din, rin, ain, bin, gin, hin, sub, use_table, eb, eg, eh, tag);
   endtask

   typedef struct {
      logic [12:0]  ctrl;
      logic [W-1:0] din;
      logic [7:0]   rin;
      logic         ain, bin, gin, hin, sub;
      logic [W-1:0] exp_bus, exp_g, exp_h;
   } vec_t;

   vec_t vecs [24];

   function automatic vec_t mk(input logic [12:0] ctrl, input logic [W-1:0] din,
                               input logic [7:0] rin, input logic ain, input logic bin,
                               input logic gin, input logic hin, input logic sub,
                               input logic [W-1:0] eb, input logic [W-1:0] eg,
                               input logic [W-1:0] eh);
      vec_t v;
      v.ctrl = ctrl; v.din = din; v.rin = rin; v.ain = ain; v.bin = bin;
      v.gin = gin; v.hin = hin; v.sub = sub;
      v.exp_bus = eb; v.exp_g = eg; v.exp_h = eh;
      return v;
   endfunction

   localparam logic [12:0] C_R0 = 13'h0001, C_R1 = 13'h0002, C_R2 = 13'h0004,
                           C_R7 = 13'h0080, C_G = 13'h0100, C_H = 13'h0200,
                           C_I = 13'h0400, C_J = 13'h0800, C_DIN = 13'h1000;

   initial begin
      //            ctrl          din      rin    A  B  G  H  sub  bus      G        H
      vecs[0]  = mk(13'h0,       16'h0,    8'h00, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
      vecs[1]  = mk(C_R0,        16'h0,    8'h00, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
      vecs[2]  = mk(C_DIN,       16'h0005, 8'h01, 0, 0, 0, 0, 0, 16'h0005, 16'h0000, 16'h0000);
      vecs[3]  = mk(C_DIN,       16'h0003, 8'h02, 0, 0, 0, 0, 0, 16'h0003, 16'h0000, 16'h0000);
      vecs[4]  = mk(C_R0,        16'h0,    8'h00, 1, 0, 0, 0, 0, 16'h0005, 16'h0000, 16'h0000);
      vecs[5]  = mk(C_R1,        16'h0,    8'h00, 0, 0, 1, 0, 0, 16'h0003, 16'h0008, 16'h0000);
      vecs[6]  = mk(C_G,         16'h0,    8'h04, 0, 0, 0, 0, 0, 16'h0008, 16'h0008, 16'h0000);
      vecs[7]  = mk(C_R2,        16'h0,    8'h00, 0, 0, 0, 0, 0, 16'h0008, 16'h0008, 16'h0000);
      vecs[8]  = mk(C_R1,        16'h0,    8'h00, 1, 0, 0, 0, 0, 16'h0003, 16'h0008, 16'h0000);
      vecs[9]  = mk(C_R0,        16'h0,    8'h00, 0, 0, 1, 0, 1, 16'h0005, 16'hFFFE, 16'h0000);
      vecs[10] = mk(C_DIN,       16'hFFFF, 8'h00, 1, 0, 0, 0, 0, 16'hFFFF, 16'hFFFE, 16'h0000);
      vecs[11] = mk(C_DIN,       16'h0001, 8'h00, 0, 0, 1, 0, 0, 16'h0001, 16'h0000, 16'h0000);
      vecs[12] = mk(C_DIN,       16'h00F0, 8'h00, 0, 1, 0, 0, 0, 16'h00F0, 16'h0000, 16'h0000);
      vecs[13] = mk(C_DIN,       16'h0F0F, 8'h00, 0, 0, 0, 1, 0, 16'h0F0F, 16'h0000, 16'h0FFF);
      vecs[14] = mk(C_H,         16'h0,    8'h80, 0, 0, 0, 0, 0, 16'h0FFF, 16'h0000, 16'h0FFF);
      vecs[15] = mk(C_R7,        16'h0,    8'h00, 0, 0, 0, 0, 0, 16'h0FFF, 16'h0000, 16'h0FFF);
      vecs[16] = mk(C_I,         16'h0,    8'h00, 0, 0, 0, 0, 0, 16'h1234, 16'h0000, 16'h0FFF);
      vecs[17] = mk(C_J,         16'h0,    8'h00, 0, 0, 0, 0, 0, 16'h5678, 16'h0000, 16'h0FFF);
      vecs[18] = mk(13'h1001,    16'hAAAA, 8'h00, 0, 0, 0, 0, 0, 16'hAAAA, 16'h0000, 16'h0FFF);
      vecs[19] = mk(C_G,         16'h0,    8'h00, 0, 0, 1, 0, 0, 16'h0000, 16'hFFFF, 16'h0FFF);
      vecs[20] = mk(C_G,         16'h0,    8'h00, 0, 0, 1, 0, 0, 16'hFFFF, 16'hFFFE, 16'h0FFF);
      vecs[21] = mk(13'h0104,    16'h0,    8'h00, 0, 0, 0, 0, 0, 16'hFFFE, 16'hFFFE, 16'h0FFF);
      vecs[22] = mk(C_R2,        16'h0,    8'h04, 0, 0, 0, 0, 0, 16'h0008, 16'hFFFE, 16'h0FFF);
      vecs[23] = mk(C_R2,        16'h0,    8'h00, 0, 0, 0, 0, 0, 16'h0008, 16'hFFFE, 16'h0FFF);

      Resetn = 1'b0; DIN = '0; Iext = 16'h1234; Jext = 16'h5678;
      Control = '0; Rin = '0; Ain = 0; Bin = 0; Gin = 0; Hin = 0; AddSubControl = 0;
      model_reset();
      repeat (2) @(negedge Clock);
      #1;
      check("rst_bus", BusWires, 16'h0000);
      check("rst_G", G, 16'h0000);
      check("rst_H", H, 16'h0000);
      Resetn = 1'b1;
      @(negedge Clock);

      // directed vector table
      for (int i = 0; i < 24; i++) begin
         step(vecs[i].ctrl, vecs[i].din, vecs[i].rin, vecs[i].ain, vecs[i].bin,
              vecs[i].gin, vecs[i].hin, vecs[i].sub, 1'b1,
              vecs[i].exp_bus, vecs[i].exp_g, vecs[i].exp_h, $sformatf("vec%0d", i));
      end

      // randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         logic [12:0] ctrl;
         case ($urandom_range(0, 3))
            0:       ctrl = '0;
            3:       ctrl = 13'($urandom);
            default: ctrl = 13'd1 << $urandom_range(0, 12);
         endcase
         Iext = 16'($urandom);
         Jext = 16'($urandom);
         step(ctrl, 16'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom), 1'($urandom), 1'b0, '0, '0, '0,
              $sformatf("rnd%0d", n));
      end

      // asynchronous reset between edges after loading everything nonzero
      for (int i = 0; i < 8; i++) begin
         step(C_DIN, 16'h1111 * 16'(i + 1), 8'd1 << i, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
              1'b0, '0, '0, '0, $sformatf("ld%0d", i));
      end
      step(C_DIN, 16'h00FF, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0, '0, '0, "ldgh");
      check("pre_rst_G_nonzero", 16'(G != 0), 16'h0001);
      Control = '0; Rin = '0; Ain = 0; Bin = 0; Gin = 0; Hin = 0;
      #2;
      Resetn = 1'b0;
      model_reset();
      #1;
      check("arst_G", G, 16'h0000);
      check("arst_H", H, 16'h0000);
      for (int i = 0; i < 10; i++) begin
         Control = 13'd1 << i;
         #1;
         check($sformatf("arst_bus_src%0d", i), BusWires, 16'h0000);
      end
      Control = C_DIN; DIN = 16'hBEEF;
      #1;
      check("arst_din_pass", BusWires, 16'hBEEF);
      Control = C_I; Iext = 16'h4321;
      #1;
      check("arst_iext_pass", BusWires, 16'h4321);
      Resetn = 1'b1;
      @(negedge Clock);
      step(C_R0, 16'h0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
           16'h0000, 16'h0000, 16'h0000, "post_rst_a");
      step(C_R1, 16'h0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
           16'h0000, 16'h0000, 16'h0000, "post_rst_add");
      step(C_R7, 16'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
           16'h0000, 16'h0000, 16'h0000, "post_rst_r7");

      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bus_alu_datapath.md
Name: bus_alu_datapath

Overview:
- Shared-bus datapath slice of the multi-cycle processor.
- Holds general registers R0-R7, the add/subtract pipeline (A operand register, Addsub unit, G result register) and the OR pipeline (B operand register, Orunit, H result register).
- A 13-source one-hot bus multiplexer drives the 16-bit bus.
- The external controller supplies all enables and selects each time step. This block contains no sequencing.

Parameters:
- W, 16, datapath/bus width in bits.

Ports:
- Clock  in  1  rising-edge clock
- Resetn  in  1  asynchronous active-low reset
- DIN  in  W  external data/immediate bus source
- Iext  in  W  external result source (slt unit), bus source 10
- Jext  in  W  external result source (shift unit), bus source 11
- Control  in  13  one-hot bus select: bits0-7 R0-R7, bit8 G, bit9 H, bit10 Iext, bit11 Jext, bit12 DIN
- Rin  in  8  per-register load enables for R0-R7 (bit n loads Rn)
- Ain  in  1  load A from bus
- Bin  in  1  load B from bus
- Gin  in  1  load G from Addsub result
- Hin  in  1  load H from Orunit result
- AddSubControl  in  1  0 = add, 1 = subtract
- BusWires  out  W  current bus value
- G  out  W  add/sub result register
- H  out  W  OR result register

Behaviour:
- Reset:
  - Resetn low asynchronously clears R0-R7, A, B, G and H to 0, regardless of Clock.
  - While reset is asserted, the bus shows 0 for register sources; DIN, Iext and Jext still pass through if selected.
  - Releasing reset mid-operation leaves all registers at 0; loads resume on the next rising edge.
- Registers:
  - Each register loads on the rising Clock edge when its enable is high; otherwise it holds.
  - Rn, A and B capture BusWires.
  - G captures the Addsub output; H captures the Orunit output.
  - Any combination of enables may be high in the same cycle; all selected registers load the same edge.
- Bus multiplexer:
  - Purely combinational, zero latency.
  - Exactly one Control bit set: the bus equals that source.
  - Control = 0: bus = 0.
  - More than one bit set: the highest-index set bit wins (DIN > Jext > Iext > H > G > R7 … > R0).
- Addsub:
  - Combinational.
  - AddSubControl = 0: result = A + BusWires.
  - AddSubControl = 1: result = A − BusWires.
  - Modulo 2^W: wrap-around is silent, no carry or overflow output.
- Orunit: combinational, result = B | BusWires (bitwise).
- Read-modify-write in one cycle is legal: e.g. Control selects G with Gin high. G then captures A ± old G, and the bus keeps the old value until after the edge.
- Loading a register that is also the bus source captures the pre-edge value; it behaves as a hold.
- Typical usage:
  - add: T1 A←Rx; T2 G←A+Ry; T3 Rx←G.
  - or: T1 B←Rx; T2 H←B|Ry; T3 Rx←H.
- G and H outputs reflect the registers directly, with no extra latency.

Test Plan:
- Reset then Control=0: BusWires=0x0000, G=H=0. Control=bit0: bus=R0=0x0000.
- Load immediates:
  - DIN=0x0005, Control=bit12, Rin[0]=1 → R0=5.
  - DIN=0x0003, Rin[1]=1 → R1=3.
  - Then add sequence (A←R0; G←A+R1; R2←G) → G=0x0008, and Control=bit2 shows 0x0008.
- Subtract wrap: A=0x0003, bus=R0=0x0005, AddSubControl=1, Gin → G=0xFFFE. Then A=0xFFFF + bus 0x0001 add → G=0x0000.
- OR: B←0x00F0, bus=0x0F0F, Hin → H=0x0FFF. Control=bit9 routes 0x0FFF onto bus into R7.
- Mux priority and externals:
  - Control=bit10 with Iext=0x1234 → bus=0x1234.
  - Control=bit11 → Jext.
  - Control=0x1001 with DIN=0xAAAA, R0=5 → bus=0xAAAA.
- Async reset mid-sequence: after loading R0-R7/G/H nonzero, pulse Resetn low between edges → all read 0 immediately. A following add yields G=0.
